rotation_cordic_engine: RTL and testbench
=========================================

ROTATION_CORDIC_ENGINE -- requirements
Module: rotation_cordic_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data/angle word width (1.4.11 signed format).
REQ-002 SHALL have parameter ITERS, default 12, number of micro-rotations (1..12).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request; samples x0/y0/theta0.
REQ-006 SHALL have port x0  input  WIDTH  signed X input, 1.4.11.
REQ-007 SHALL have port y0  input  WIDTH  signed Y input, 1.4.11.
REQ-008 SHALL have port theta0  input  WIDTH  signed rotation angle, radians, 1.4.11, |theta0| <= 3217 (pi/2).
REQ-009 SHALL have port busy  output  1  high while a rotation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port x_n  output  WIDTH  signed rotated X, 1.4.11.
REQ-012 SHALL have port y_n  output  WIDTH  signed rotated Y, 1.4.11.
REQ-013 SHALL have port theta_n  output  WIDTH  signed residual angle after last iteration.

Function
REQ-014 SHALL implement FSM IDLE -> ROTATE -> (GAIN, if enabled) -> DONE -> IDLE.
REQ-015 SHALL accept start only in IDLE; on acceptance latch x0, y0, theta0 into x, y, z, clear iteration counter i, enter ROTATE.
REQ-016 SHALL ignore start while busy=1 or in DONE; no effect on in-flight operation.
REQ-017 SHALL, per ROTATE cycle, with d = (z >= 0): d: x<=x-(y>>>i), y<=y+(x>>>i), z<=z-atan(i); !d: x<=x+(y>>>i), y<=y-(x>>>i), z<=z+atan(i); then i<=i+1.
REQ-018 SHALL use arithmetic shifts and an internal datapath of WIDTH+2 bits for x, y; z in WIDTH bits.
REQ-019 SHALL leave ROTATE after exactly ITERS cycles (i == ITERS-1).
REQ-020 SHALL in DONE saturate x, y to [-32768, 32767] (WIDTH=16), load x_n, y_n, theta_n, assert done for one cycle.
REQ-021 SHALL hold x_n, y_n, theta_n stable until the next done.
REQ-022 SHALL assert busy from the cycle after start acceptance through the done cycle inclusive.
REQ-023 SHALL give latency start-sampled edge to done = ITERS+1 cycles (ITERS+2 with gain compensation).
REQ-024 SHALL accept a new start in the cycle immediately after done (back-to-back).

Reset
REQ-025 SHALL, when rst=0 at a clock edge, force IDLE, busy=0, done=0, x_n=y_n=theta_n=0, clear internal registers, including mid-operation; the aborted result SHALL never be output.

Configuration
REQ-026 SHALL, with macro CORDIC_GAIN_COMP_EN defined, insert GAIN state (one cycle) multiplying x, y by K=1244 (0.60725, 1.4.11) with round-half-up before saturation.
REQ-027 SHALL, without CORDIC_GAIN_COMP_EN, output uncompensated results (gain ~1.6468); no multiplier present.

Structure
REQ-028 SHALL take from shared package cordic_pkg: WIDTH default, ITERS max, atan table (1608,950,502,255,128,64,32,16,8,4,2,1), K=1244, FSM state typedef.
REQ-029 SHALL instantiate one sub-module cordic_rot_stage: combinational single micro-rotation (x,y,z,i,atan in; x',y',z' out), reusable by the vectoring path.

Verification
REQ-030 x0=2048,y0=0,theta0=0 -> no comp: x_n=3373+/-4, y_n=0+/-4; comp: x_n=2048+/-4, y_n=0+/-4; theta_n within +/-2.
REQ-031 x0=2048,y0=0,theta0=3217 -> no comp: x_n=0+/-4, y_n=3373+/-4; done exactly 13 cycles after start.
REQ-032 x0=2048,y0=0,theta0=1608 -> no comp: x_n=y_n=2385+/-4; theta0=-1608 -> y_n=-2385+/-4.
REQ-033 x0=y0=15000,theta0=1608, no comp -> y_n saturates to 32767, x_n=0+/-8.
REQ-034 start pulsed again 5 cycles into operation with different operands -> ignored; single done with first operand's result.
REQ-035 rst=0 for one cycle at iteration 6 -> busy=0, outputs 0 next cycle, no done; subsequent start completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctangent table and FSM state type for the CORDIC engines.
// Contents:
//   WIDTH_DEF  default data/angle word width (1.4.11 signed)
//   ITERS_MAX  largest supported micro-rotation count
//   FRAC       fractional bits of the 1.4.11 format
//   K_GAIN     CORDIC gain compensation constant 0.60725 in 1.4.11
//   ATAN_LUT   atan(2^-i) in 1.4.11 radians, i = 0..ITERS_MAX-1
//   state_t    engine FSM states
package cordic_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int ITERS_MAX = 12;
    localparam int FRAC = 11;
    localparam int K_GAIN = 1244;
    localparam logic [15:0] ATAN_LUT [ITERS_MAX] = '{
        16'd1608, 16'd950, 16'd502, 16'd255, 16'd128, 16'd64,
        16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1
    };
    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_GAIN, S_DONE} state_t;
endpackage

// File: rtl/cordic_rot_stage.sv
// cordic_rot_stage: one combinational CORDIC micro-rotation step.
// Ports:
//   i_x, i_y   extended-width signed vector components
//   i_z        signed residual angle; its sign picks the rotation direction
//   i_i        iteration index (shift amount)
//   i_atan     atan(2^-i) for this iteration
//   o_x, o_y   rotated vector components
//   o_z        updated residual angle
module cordic_rot_stage #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH+1:0] i_x,
    input  logic signed [WIDTH+1:0] i_y,
    input  logic signed [WIDTH-1:0] i_z,
    input  logic        [3:0]       i_i,
    input  logic signed [WIDTH-1:0] i_atan,
    output logic signed [WIDTH+1:0] o_x,
    output logic signed [WIDTH+1:0] o_y,
    output logic signed [WIDTH-1:0] o_z
);
    logic                   w_d;
    logic signed [WIDTH+1:0] w_xs;
    logic signed [WIDTH+1:0] w_ys;

    assign w_d  = ~i_z[WIDTH-1];
    assign w_xs = i_x >>> i_i;
    assign w_ys = i_y >>> i_i;
    assign o_x  = w_d ? i_x - w_ys : i_x + w_ys;
    assign o_y  = w_d ? i_y + w_xs : i_y - w_xs;
    assign o_z  = w_d ? i_z - i_atan : i_z + i_atan;
endmodule

// File: rtl/rotation_cordic_engine.sv
// rotation_cordic_engine: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   start             one-cycle request, accepted only when idle
//   x0, y0, theta0    signed 1.4.11 operands (|theta0| <= pi/2)
//   busy              high from the cycle after acceptance through the done cycle
//   done              one-cycle pulse, results valid
//   x_n, y_n, theta_n saturated rotated vector and residual angle, held until next done
// Build option: define CORDIC_GAIN_COMP_EN to add a GAIN state scaling x, y by K.
module rotation_cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITERS = ITERS_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] theta0,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_n,
    output logic signed [WIDTH-1:0] y_n,
    output logic signed [WIDTH-1:0] theta_n
);
    localparam int DW = WIDTH + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t S_POST = S_GAIN;
`else
    localparam state_t S_POST = S_DONE;
`endif

    state_t                  r_state, w_next;
    logic signed [DW-1:0]    r_x, r_y, w_x, w_y;
    logic signed [WIDTH-1:0] r_z, w_z, w_atan;
    logic signed [WIDTH-1:0] r_xn, r_yn, r_tn;
    logic        [3:0]       r_i;
    logic                    r_done;
    logic                    w_accept;

    // Clamp the extended datapath to the output word: in range iff the guard bits match the sign.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
        return (&v[DW-1:WIDTH-1] || ~|v[DW-1:WIDTH-1]) ? v[WIDTH-1:0]
                                                       : {v[DW-1], {(WIDTH-1){~v[DW-1]}}};
    endfunction

    assign w_atan   = WIDTH'(ATAN_LUT[r_i]);
    assign w_accept = (r_state == S_IDLE) && start && !r_done;
    assign busy     = (r_state != S_IDLE) || r_done;
    assign done     = r_done;
    assign x_n      = r_xn;
    assign y_n      = r_yn;
    assign theta_n  = r_tn;

    cordic_rot_stage #(.WIDTH(WIDTH)) u_stage (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .i_i   (r_i),
        .i_atan(w_atan),
        .o_x   (w_x),
        .o_y   (w_y),
        .o_z   (w_z)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [13:0] K_S = 14'(K_GAIN);
    logic signed [DW+13:0] w_px, w_py;
    logic signed [DW-1:0]  w_gx, w_gy;
    assign w_px = r_x * K_S;
    assign w_py = r_y * K_S;
    assign w_gx = DW'((w_px + (DW+14)'(1 << (FRAC-1))) >>> FRAC);
    assign w_gy = DW'((w_py + (DW+14)'(1 << (FRAC-1))) >>> FRAC);
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_ROTATE : S_IDLE;
            S_ROTATE: w_next = (r_i == 4'(ITERS-1)) ? S_POST : S_ROTATE;
            S_GAIN:   w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_i    <= '0;
            r_done <= 1'b0;
            r_xn   <= '0;
            r_yn   <= '0;
            r_tn   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_x <= DW'(x0);
                r_y <= DW'(y0);
                r_z <= theta0;
                r_i <= '0;
            end
            if (r_state == S_ROTATE) begin
                r_x <= w_x;
                r_y <= w_y;
                r_z <= w_z;
                r_i <= r_i + 4'd1;
            end
`ifdef CORDIC_GAIN_COMP_EN
            if (r_state == S_GAIN) begin
                r_x <= w_gx;
                r_y <= w_gy;
            end
`endif
            if (r_state == S_DONE) begin
                r_xn   <= sat(r_x);
                r_yn   <= sat(r_y);
                r_tn   <= r_z;
                r_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rotation_cordic_engine.sv
// tb_rotation_cordic_engine: directed vector table plus corner-case sequences for the CORDIC engine.
module tb_rotation_cordic_engine;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x0 = '0, y0 = '0, theta0 = '0;
    logic               busy, done;
    logic signed [15:0] x_n, y_n, theta_n;

`ifdef CORDIC_GAIN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif
    localparam int LAT = COMP ? 14 : 13;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    x0, y0, th, ex, ey, tol;
    } vec_t;
    vec_t v[8];

    always #5 clk = ~clk;

    rotation_cordic_engine #(.WIDTH(16), .ITERS(12)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .theta0(theta0),
        .busy(busy), .done(done),
        .x_n(x_n), .y_n(y_n), .theta_n(theta_n)
    );

    // Ideal uncompensated value -> expected output for this build.
    function automatic int expv(input int raw);
        if (COMP) return (raw * 1244 + 1024) >>> 11;
        return raw > 32767 ? 32767 : (raw < -32768 ? -32768 : raw);
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d want %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    task automatic run_op(input int xa, input int ya, input int ta, output int lat);
        @(posedge clk); #1;
        x0 = 16'(xa); y0 = 16'(ya); theta0 = 16'(ta); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, nd, gx, gy;
        v[0] = '{"zero", 2048, 0, 0, 3373, 0, 4};
        v[1] = '{"p90", 2048, 0, 3217, 0, 3373, 4};
        v[2] = '{"p45", 2048, 0, 1608, 2385, 2385, 4};
        v[3] = '{"m45", 2048, 0, -1608, 2385, -2385, 4};
        v[4] = '{"m90", 2048, 0, -3217, 0, -3373, 4};
        v[5] = '{"yin", 0, 2048, 0, 0, 3373, 4};
        v[6] = '{"negx", -2048, 0, 0, -3373, 0, 6};
        v[7] = '{"sat", 15000, 15000, 1608, 0, 34933, 8};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_xn", x_n, 0, 0);
        chk("rst_yn", y_n, 0, 0);
        chk("rst_tn", theta_n, 0, 0);
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_op(v[k].x0, v[k].y0, v[k].th, lat);
            chk({v[k].name, "_lat"}, lat, LAT, 0);
            chk({v[k].name, "_x"}, x_n, expv(v[k].ex), v[k].tol);
            chk({v[k].name, "_y"}, y_n, expv(v[k].ey), v[k].tol);
            chk({v[k].name, "_th"}, theta_n, 0, 2);
        end

        // busy window and single-cycle done
        @(posedge clk); #1;
        x0 = 16'sd2048; y0 = 16'sd0; theta0 = 16'sd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1, 0);
        chk("no_early_done", int'(done), 0, 0);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_in_done", int'(busy), 1, 0);
        @(posedge clk); #1;
        chk("done_pulse_width", int'(done), 0, 0);
        chk("busy_cleared", int'(busy), 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_x", x_n, expv(3373), 4);

        // start pulsed mid-operation must be ignored
        @(posedge clk); #1;
        x0 = 16'sd2048; y0 = 16'sd0; theta0 = 16'sd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; gx = 0; gy = 0;
        for (int c = 1; c < 40; c++) begin
            if (c == 5) begin
                x0 = 16'sd0; y0 = 16'sd2048; theta0 = 16'sd3217; start = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                nd++; gx = x_n; gy = y_n;
            end
        end
        start = 1'b0;
        chk("ign_done_count", nd, 1, 0);
        chk("ign_x", gx, expv(3373), 4);
        chk("ign_y", gy, expv(0), 4);

        // reset in the middle of an operation
        @(posedge clk); #1;
        x0 = 16'sd2048; y0 = 16'sd0; theta0 = 16'sd1608; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0, 0);
        chk("abort_done", int'(done), 0, 0);
        chk("abort_xn", x_n, 0, 0);
        chk("abort_yn", y_n, 0, 0);
        chk("abort_tn", theta_n, 0, 0);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0, 0);
        run_op(2048, 0, 3217, lat);
        chk("post_lat", lat, LAT, 0);
        chk("post_x", x_n, expv(0), 4);
        chk("post_y", y_n, expv(3373), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
